// File: rtl/pc_gen_pkg.sv
// pc_gen shared types: next-PC source select and its priority encoder.
// Shared by pc_gen; see pc_gen.sv for the PC_ALIGN_CHK_EN option.
package pc_gen_pkg;

  typedef enum logic [2:0] {
    SRC_INIT,
    SRC_FLUSH,
    SRC_HOLD,
    SRC_PEND,
    SRC_BR,
    SRC_SEQ
  } src_e;

  // First edge after reset only arms the fetch; the PC stays put.
  function automatic src_e pick_src(
    input logic run,
    input logic flush,
    input logic stall,
    input logic pend,
    input logic br
  );
    if (!run)       return SRC_INIT;
    else if (flush) return SRC_FLUSH;
    else if (stall) return SRC_HOLD;
    else if (pend)  return SRC_PEND;
    else if (br)    return SRC_BR;
    else            return SRC_SEQ;
  endfunction

endpackage

// File: rtl/pc_gen.sv
// Fetch-address generator with stall hold and a one-entry pending branch.
// Define PC_ALIGN_CHK_EN to add misalign_o and suppress misaligned fetches.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int          STEP      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] new_pc_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_address_i,
  output logic [ADDR_W-1:0] inst_addr,
  output logic              inst_ce,
`ifdef PC_ALIGN_CHK_EN
  output logic              misalign_o,
`endif
  output logic              pend_valid_o
);

  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_VEC);
  localparam logic [ADDR_W-1:0] STEP_W = ADDR_W'(STEP);

  logic              run;
  logic [ADDR_W-1:0] pend_tgt;
  logic [ADDR_W-1:0] next_pc;
  logic              pend_nxt_v;
  logic [ADDR_W-1:0] pend_nxt_t;
  logic              ce_nxt;
  src_e              src;

`ifdef PC_ALIGN_CHK_EN
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STEP - 1);
  logic mis_nxt;
  assign mis_nxt = |(next_pc & ALIGN_MASK);
  assign ce_nxt  = ~mis_nxt;
`else
  assign ce_nxt  = 1'b1;
`endif

  always_comb begin
    src = pick_src(run, flush_i, stall_i,
                   pend_valid_o, branch_flag_i);
    next_pc    = inst_addr;
    pend_nxt_v = pend_valid_o;
    pend_nxt_t = pend_tgt;
    unique case (src)
      SRC_INIT: ;
      SRC_FLUSH: begin
        next_pc    = new_pc_i;
        pend_nxt_v = 1'b0;
      end
      SRC_HOLD: begin
        if (branch_flag_i) begin
          pend_nxt_v = 1'b1;
          pend_nxt_t = branch_target_address_i;
        end
      end
      // A live branch supersedes the buffered one.
      SRC_PEND: begin
        next_pc    = branch_flag_i ? branch_target_address_i
                                   : pend_tgt;
        pend_nxt_v = 1'b0;
      end
      SRC_BR:  next_pc = branch_target_address_i;
      SRC_SEQ: next_pc = inst_addr + STEP_W;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run          <= 1'b0;
      inst_addr    <= RST_PC;
      inst_ce      <= 1'b0;
      pend_valid_o <= 1'b0;
      pend_tgt     <= '0;
`ifdef PC_ALIGN_CHK_EN
      misalign_o   <= 1'b0;
`endif
    end else begin
      run          <= 1'b1;
      inst_addr    <= next_pc;
      inst_ce      <= ce_nxt;
      pend_valid_o <= pend_nxt_v;
      pend_tgt     <= pend_nxt_t;
`ifdef PC_ALIGN_CHK_EN
      misalign_o   <= mis_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed cases plus random stimulus
// against a behavioural next-PC model.
module tb_pc_gen;

  localparam int          AW   = 32;
  localparam logic [31:0] RV   = 32'hbfc0_0000;
  localparam int          STEP = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic [AW-1:0] new_pc = '0;
  logic          br = 1'b0;
  logic [AW-1:0] br_tgt = '0;
  logic [AW-1:0] inst_addr;
  logic          inst_ce;
  logic          pend_valid;
`ifdef PC_ALIGN_CHK_EN
  logic          misalign;
`endif

  always #5 clk = ~clk;

  pc_gen #(
    .ADDR_W(AW),
    .RESET_VEC(RV),
    .STEP(STEP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stall_i(stall),
    .flush_i(flush),
    .new_pc_i(new_pc),
    .branch_flag_i(br),
    .branch_target_address_i(br_tgt),
    .inst_addr(inst_addr),
    .inst_ce(inst_ce),
`ifdef PC_ALIGN_CHK_EN
    .misalign_o(misalign),
`endif
    .pend_valid_o(pend_valid)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model: PC, fetch enable, started flag, pending queue.
  logic [31:0] m_pc  = RV;
  logic        m_ce  = 1'b0;
  logic        m_run = 1'b0;
  logic        m_mis = 1'b0;
  logic [31:0] pq[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic model_update();
    if (rst) begin
      m_pc  = RV;
      m_ce  = 1'b0;
      m_run = 1'b0;
      m_mis = 1'b0;
      pq.delete();
    end else begin
      if (!m_run) begin
        m_run = 1'b1;
      end else if (flush) begin
        m_pc = new_pc;
        pq.delete();
      end else if (stall) begin
        if (br) begin
          pq.delete();
          pq.push_back(br_tgt);
        end
      end else if (pq.size() != 0) begin
        m_pc = br ? br_tgt : pq[0];
        pq.delete();
      end else if (br) begin
        m_pc = br_tgt;
      end else begin
        m_pc = m_pc + 32'(STEP);
      end
`ifdef PC_ALIGN_CHK_EN
      m_mis = (m_pc % STEP) != 0;
      m_ce  = !m_mis;
`else
      m_ce  = 1'b1;
`endif
    end
  endtask

  // One clock: inputs already applied, model follows the edge, then compare.
  task automatic step();
    @(posedge clk);
    #1;
    model_update();
    chk("addr", inst_addr, m_pc);
    chk("ce", {31'b0, inst_ce}, {31'b0, m_ce});
    chk("pend", {31'b0, pend_valid}, {31'b0, pq.size() != 0});
`ifdef PC_ALIGN_CHK_EN
    chk("misalign", {31'b0, misalign}, {31'b0, m_mis});
`endif
  endtask

  task automatic drive(input logic r, input logic f, input logic s,
                       input logic b, input logic [31:0] npc,
                       input logic [31:0] bt);
    rst    = r;
    flush  = f;
    stall  = s;
    br     = b;
    new_pc = npc;
    br_tgt = bt;
    step();
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic go(input logic [31:0] pc);
    drive(1'b0, 1'b1, 1'b0, 1'b0, pc, '0);
  endtask

  // Literal expectation checked against both DUT and model.
  task automatic lit(input string nm, input logic [31:0] exp);
    chk(nm, inst_addr, exp);
    chk({nm, "_model"}, m_pc, exp);
  endtask

  task automatic lit_pend(input string nm, input logic exp);
    chk(nm, {31'b0, pend_valid}, {31'b0, exp});
  endtask

  initial begin
    logic r, f, s, b;
    logic [31:0] npc, bt;

    repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    lit("rst_addr", 32'hbfc0_0000);
    chk("rst_ce", {31'b0, inst_ce}, 32'd0);

    idle();
    lit("rel_addr", 32'hbfc0_0000);
    chk("rel_ce", {31'b0, inst_ce}, 32'd1);
    idle();
    lit("seq1", 32'hbfc0_0004);
    idle();
    lit("seq2", 32'hbfc0_0008);

    go(32'h100);
    lit("at_100", 32'h100);
    drive(1'b0, 1'b0, 1'b0, 1'b1, '0, 32'h200);
    lit("br_200", 32'h200);
    idle();
    lit("br_204", 32'h204);

    go(32'h40);
    drive(1'b0, 1'b0, 1'b1, 1'b1, '0, 32'h80);
    lit("stall1", 32'h40);
    lit_pend("stall1_pend", 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b1, '0, 32'h90);
    lit("stall2", 32'h40);
    drive(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
    lit("stall3", 32'h40);
    lit_pend("stall3_pend", 1'b1);
    idle();
    lit("pend_90", 32'h90);
    lit_pend("pend_clr", 1'b0);
    idle();
    lit("pend_94", 32'h94);

    drive(1'b0, 1'b0, 1'b1, 1'b1, '0, 32'h1234);
    lit_pend("pre_flush_pend", 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'hbfc0_0380, 32'h500);
    lit("flush_win", 32'hbfc0_0380);
    lit_pend("flush_pend", 1'b0);

    go(32'hffff_fffc);
    lit("wrap_pre", 32'hffff_fffc);
    idle();
    lit("wrap", 32'h0);

`ifdef PC_ALIGN_CHK_EN
    go(32'h100);
    drive(1'b0, 1'b0, 1'b0, 1'b1, '0, 32'h102);
    lit("mis_102", 32'h102);
    chk("mis_flag", {31'b0, misalign}, 32'd1);
    chk("mis_ce", {31'b0, inst_ce}, 32'd0);
    go(32'h380);
    lit("mis_fix", 32'h380);
    chk("mis_clr", {31'b0, misalign}, 32'd0);
    chk("mis_ce1", {31'b0, inst_ce}, 32'd1);
`endif

    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom % 64) == 0;
      f   = ($urandom % 16) == 0;
      s   = ($urandom % 4) == 0;
      b   = ($urandom % 4) == 0;
      npc = $urandom & 32'hffff_fffc;
      bt  = $urandom & 32'hffff_fffc;
      if (($urandom % 8) == 0) npc = 32'hffff_fff0;
      if (($urandom % 16) == 0) bt = bt | 32'(($urandom % 3) + 1);
      drive(r, f, s, b, npc, bt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
